// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg;

  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DATA_W = 32;

  // addi x0, x0, 0 : returned in place of data for faulting fetches
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Byte address to word index: drop the two byte-offset bits
  function automatic int word_index_width(input int addr_w);
    return addr_w - 2;
  endfunction

  // One queued fetch response
  typedef struct packed {
    logic [IMEM_DATA_W-1:0] instr;
    logic [IMEM_ADDR_W-1:0] addr;
    logic                   error;
  } imem_rsp_t;

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch request/response handshake bundle between the PC stage and instruction memory.
interface imem_fetch_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_error;

  // Fetch unit side: issues addresses and consumes instructions
  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_error
  );

  // Memory side: accepts addresses and produces instructions
  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_error
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Small response queue that lets decode stall without losing fetched words.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int RSP_DEPTH = 2,
  localparam int PTR_W = $clog2(RSP_DEPTH),
  localparam int OCC_W = $clog2(RSP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  imem_rsp_t        push_data,
  input  logic             pop,
  input  logic             flush,
  output imem_rsp_t        head,
  output logic [OCC_W-1:0] occ
);

  imem_rsp_t        entries [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = entries[rd_ptr];

  // Queue state: flush empties the queue but leaves stale entry contents in place
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        entries[i] <= '{instr: NOP, addr: '0, error: 1'b0};
      end
    end else if (flush) begin
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction-memory responder: looks up a word per accepted fetch and queues it for decode.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH  = IMEM_ADDR_W,
  parameter int DATA_WIDTH  = IMEM_DATA_W,
  parameter int DEPTH_WORDS = 128,
  parameter int RSP_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  imem_fetch_if.slave           bus,
  input  logic                  flush,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-3:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int WORD_W    = word_index_width(ADDR_WIDTH);
  localparam int MEM_IDX_W = $clog2(DEPTH_WORDS);
  localparam int OCC_W     = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [WORD_W-1:0]     word_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] rd_word;
  imem_rsp_t             new_entry;
  imem_rsp_t             head;
  logic [OCC_W-1:0]      occ;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Address decode and lookup; faulting fetches never touch the array
  always_comb begin
    word_idx     = bus.req_addr[ADDR_WIDTH-1:2];
    misaligned   = |bus.req_addr[1:0];
    out_of_range = int'(word_idx) >= DEPTH_WORDS;
    req_err      = misaligned | out_of_range;
    rd_word      = req_err ? DATA_WIDTH'(NOP) : mem[word_idx[MEM_IDX_W-1:0]];
    new_entry    = '{instr: rd_word, addr: bus.req_addr, error: req_err};
  end

  assign full  = (occ == OCC_W'(RSP_DEPTH));
  assign empty = (occ == '0);

  assign bus.req_ready = reset_n & ~load_en & ~flush & ~full;
  assign bus.rsp_valid = reset_n & ~empty & ~flush;
  assign bus.rsp_instr = head.instr;
  assign bus.rsp_addr  = head.addr;
  assign bus.rsp_error = head.error;

  assign push = bus.req_valid & bus.req_ready;
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  // Program-image load port; memory survives reset, writes past the array end are dropped
  always_ff @(posedge clk) begin
    if (load_en && (int'(load_addr) < DEPTH_WORDS)) begin
      mem[load_addr[MEM_IDX_W-1:0]] <= load_data;
    end
  end

  imem_rsp_fifo #(
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (new_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .occ       (occ)
  );

endmodule

// File: tb/tb_imem_fetch.sv
// Directed scoreboard bench for imem_fetch (64-word memory, 2-entry response queue).
module tb_imem_fetch;
  import imem_pkg::*;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int RSPD   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        load_en;
  logic [6:0]  load_addr;
  logic [31:0] load_data;

  imem_fetch_if #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W)) bus ();

  imem_fetch #(
    .ADDR_WIDTH  (ADDR_W),
    .DATA_WIDTH  (DATA_W),
    .DEPTH_WORDS (DEPTH),
    .RSP_DEPTH   (RSPD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  int        vectors     = 0;
  int        miscompares = 0;
  imem_rsp_t exp_q[$];
  imem_rsp_t exp_item;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge, then sample at the falling edge
  task automatic applyStimulus(input logic rst_n, input logic rv, input logic [8:0] ra,
                               input logic rr, input logic fl, input logic ld,
                               input logic [6:0] la, input logic [31:0] ldd,
                               input logic exp_ready, input logic [31:0] exp_instr,
                               input logic exp_err);
    @(posedge clk);
    #1;
    reset_n       = rst_n;
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.rsp_ready = rr;
    flush         = fl;
    load_en       = ld;
    load_addr     = la;
    load_data     = ldd;
    @(negedge clk);
    if (rv) checkOutput("req_ready", {31'b0, bus.req_ready}, {31'b0, exp_ready});
    if (rv && exp_ready) exp_q.push_back('{instr: exp_instr, addr: ra, error: exp_err});
    if (fl || !rst_n) exp_q.delete();
  endtask

  task automatic req(input logic [8:0] addr, input logic rr, input logic exp_ready,
                     input logic [31:0] exp_instr, input logic exp_err);
    applyStimulus(1'b1, 1'b1, addr, rr, 1'b0, 1'b0, 7'd0, 32'd0, exp_ready, exp_instr, exp_err);
  endtask

  task automatic idle(input logic rr);
    applyStimulus(1'b1, 1'b0, 9'd0, rr, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic load(input logic [6:0] idx, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 1'b1, idx, data, 1'b0, 32'd0, 1'b0);
  endtask

  // Monitor: every response handed over must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("rsp_instr", bus.rsp_instr, exp_item.instr);
        checkOutput("rsp_addr", {23'b0, bus.rsp_addr}, {23'b0, exp_item.addr});
        checkOutput("rsp_error", {31'b0, bus.rsp_error}, {31'b0, exp_item.error});
      end
    end
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sequence did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    flush         = 1'b0;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;

    // Reset: nothing accepted, nothing presented
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      checkOutput("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    end

    // Program image
    load(7'd0, 32'hA0);
    load(7'd1, 32'hA1);
    load(7'd2, 32'hA2);
    load(7'd3, 32'hA3);
    load(7'd63, 32'hC3);

    // 1: back-to-back fetches, one cycle latency, full throughput
    req(9'd0, 1'b1, 1'b1, 32'hA0, 1'b0);
    checkOutput("t1_latency", {31'b0, bus.rsp_valid}, 32'd0);
    req(9'd4, 1'b1, 1'b1, 32'hA1, 1'b0);
    checkOutput("t1_valid1", {31'b0, bus.rsp_valid}, 32'd1);
    req(9'd8, 1'b1, 1'b1, 32'hA2, 1'b0);
    checkOutput("t1_valid2", {31'b0, bus.rsp_valid}, 32'd1);
    req(9'd12, 1'b1, 1'b1, 32'hA3, 1'b0);
    checkOutput("t1_valid3", {31'b0, bus.rsp_valid}, 32'd1);
    idle(1'b1);
    checkOutput("t1_valid4", {31'b0, bus.rsp_valid}, 32'd1);
    idle(1'b1);
    checkOutput("t1_drained", {31'b0, bus.rsp_valid}, 32'd0);

    // 2: backpressure fills the queue, head holds, then drains in order
    req(9'd0, 1'b0, 1'b1, 32'hA0, 1'b0);
    req(9'd4, 1'b0, 1'b1, 32'hA1, 1'b0);
    checkOutput("t2_head0", bus.rsp_instr, 32'hA0);
    req(9'd8, 1'b0, 1'b0, 32'hA2, 1'b0);
    checkOutput("t2_head1", bus.rsp_instr, 32'hA0);
    idle(1'b0);
    checkOutput("t2_head2", bus.rsp_instr, 32'hA0);
    req(9'd8, 1'b1, 1'b0, 32'hA2, 1'b0);
    req(9'd8, 1'b1, 1'b1, 32'hA2, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("t2_drained", {31'b0, bus.rsp_valid}, 32'd0);

    // 3: misaligned, last valid word, first and last out-of-range words
    req(9'd6, 1'b1, 1'b1, 32'h13, 1'b1);
    req(9'h0FC, 1'b1, 1'b1, 32'hC3, 1'b0);
    req(9'h100, 1'b1, 1'b1, 32'h13, 1'b1);
    req(9'h1FC, 1'b1, 1'b1, 32'h13, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // 4: flush discards the queue and blocks the request in that cycle
    req(9'd0, 1'b0, 1'b1, 32'hA0, 1'b0);
    req(9'd4, 1'b0, 1'b1, 32'hA1, 1'b0);
    applyStimulus(1'b1, 1'b1, 9'd8, 1'b1, 1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("t4_flush_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    idle(1'b1);
    checkOutput("t4_after_flush_empty", {31'b0, bus.rsp_valid}, 32'd0);
    req(9'd4, 1'b1, 1'b1, 32'hA1, 1'b0);
    idle(1'b1);

    // 5: load blocks requests; in-range write lands, out-of-range write is dropped
    applyStimulus(1'b1, 1'b1, 9'd8, 1'b1, 1'b0, 1'b1, 7'd2, 32'hBEEF, 1'b0, 32'd0, 1'b0);
    req(9'd8, 1'b1, 1'b1, 32'hBEEF, 1'b0);
    idle(1'b1);
    load(7'd66, 32'hDEAD);
    req(9'd8, 1'b1, 1'b1, 32'hBEEF, 1'b0);
    idle(1'b1);

    // 6: reset mid-operation drops the queue but keeps memory
    load(7'd2, 32'hA2);
    req(9'd0, 1'b0, 1'b1, 32'hA0, 1'b0);
    req(9'd4, 1'b0, 1'b1, 32'hA1, 1'b0);
    applyStimulus(1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    checkOutput("t6_reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    idle(1'b1);
    checkOutput("t6_after_reset_empty", {31'b0, bus.rsp_valid}, 32'd0);
    req(9'd0, 1'b1, 1'b1, 32'hA0, 1'b0);
    req(9'd8, 1'b1, 1'b1, 32'hA2, 1'b0);
    idle(1'b1);
    idle(1'b1);

    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
